// File: rtl/core_alu_seq.sv
// core_alu_seq: sequential RV-style integer ALU with an optional iterative
// multiply/divide unit.
//
// Configuration macro: CORE_ALU_SEQ_MULDIV_EN
//   defined   -> ops 10-17 (MUL..REMU) are implemented. They run through CALC
//                for XLEN cycles, one bit per cycle.
//   undefined -> no multiplier/divider is built. Ops 10-17 report illegal in
//                one cycle, and CALC is never entered.
//
// Handshake (valid/ready, both directions):
//   request : accepted on a rising edge where i_valid=1 and o_ready=1. All
//             request inputs are sampled on that edge only.
//   response: o_valid stays high until the edge where i_ready=1. o_result and
//             o_illegal hold steady while o_valid=1 and i_ready=0.
//
// dbg_state exposes the FSM encoding (IDLE=0, CALC=1, DONE=2).
module core_alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_use_imm,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal,
  output logic [1:0]      dbg_state
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
`ifdef CORE_ALU_SEQ_MULDIV_EN
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] result_q;
  logic            illegal_q;

  logic [XLEN-1:0] opnd_b;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] fast_res;
  logic            fast_ill;
  logic            go_calc;

  assign opnd_b    = i_use_imm ? i_imm : i_rs2;
  assign shamt     = opnd_b[SHW-1:0];
  assign o_ready   = (state == IDLE);
  assign o_valid   = (state == DONE);
  assign o_result  = result_q;
  assign o_illegal = illegal_q;
  assign dbg_state = state;

`ifdef CORE_ALU_SEQ_MULDIV_EN
  // Iteration state: acc_hi/acc_lo hold the partial product, or the partial
  // remainder and the quotient. mcand holds the multiplicand or the divisor.
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] mcand;
  logic [4:0]      op_q;
  logic            neg_q;
  logic            neg_r;

  logic            div_zero;
  logic            div_ovf;
  logic            signed_a;
  logic            signed_b;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  logic            is_div_q;
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] diff;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] md_res;

  assign div_zero = (opnd_b == '0);
  assign div_ovf  = (i_rs1 == MIN_NEG) && (opnd_b == '1);
  // MUL uses unsigned magnitudes; its low half is the same either way.
  assign signed_a = (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                    (i_op == OP_DIV)  || (i_op == OP_REM);
  assign signed_b = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
  assign a_neg    = signed_a && i_rs1[XLEN-1];
  assign b_neg    = signed_b && opnd_b[XLEN-1];
  assign abs_a    = a_neg ? (-i_rs1)  : i_rs1;
  assign abs_b    = b_neg ? (-opnd_b) : opnd_b;
  assign is_div_q = (op_q >= OP_DIV);

  // One iteration step: restoring divide or shift-add multiply.
  always_comb begin
    shifted = {acc_hi, acc_lo[XLEN-1]};
    ge      = (shifted >= {1'b0, mcand});
    diff    = shifted[XLEN-1:0] - mcand;
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
    if (is_div_q) begin
      step_hi = ge ? diff : shifted[XLEN-1:0];
      step_lo = {acc_lo[XLEN-2:0], ge};
    end else begin
      step_hi = sum[XLEN:1];
      step_lo = {sum[0], acc_lo[XLEN-1:1]};
    end
  end

  // Sign correction and result selection, applied to the final step's output.
  always_comb begin
    prod_fix = neg_q ? (-{step_hi, step_lo}) : {step_hi, step_lo};
    quo_fix  = neg_q ? (-step_lo) : step_lo;
    rem_fix  = neg_r ? (-step_hi) : step_hi;
    md_res   = '0;
    case (op_q)
      OP_MUL:                       md_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              md_res = quo_fix;
      OP_REM, OP_REMU:              md_res = rem_fix;
      default:                      md_res = '0;
    endcase
  end
`endif

  // Single-cycle results, division special cases and the CALC decision.
  always_comb begin
    fast_res = '0;
    fast_ill = 1'b0;
    go_calc  = 1'b0;
    case (i_op)
      OP_ADD:  fast_res = i_rs1 + opnd_b;
      OP_SUB:  fast_res = i_rs1 - opnd_b;
      OP_SLL:  fast_res = i_rs1 << shamt;
      OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, ($signed(i_rs1) < $signed(opnd_b))};
      OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, (i_rs1 < opnd_b)};
      OP_XOR:  fast_res = i_rs1 ^ opnd_b;
      OP_SRL:  fast_res = i_rs1 >> shamt;
      OP_SRA:  fast_res = $unsigned($signed(i_rs1) >>> shamt);
      OP_OR:   fast_res = i_rs1 | opnd_b;
      OP_AND:  fast_res = i_rs1 & opnd_b;
`ifdef CORE_ALU_SEQ_MULDIV_EN
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: go_calc = 1'b1;
      OP_DIV, OP_DIVU: begin
        if (div_zero)                      fast_res = '1;
        else if (i_op == OP_DIV && div_ovf) fast_res = i_rs1;
        else                               go_calc  = 1'b1;
      end
      OP_REM, OP_REMU: begin
        if (div_zero)                      fast_res = i_rs1;
        else if (i_op == OP_REM && div_ovf) fast_res = '0;
        else                               go_calc  = 1'b1;
      end
`endif
      default: fast_ill = 1'b1;
    endcase
  end

  // Control FSM with registered result and illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef CORE_ALU_SEQ_MULDIV_EN
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      mcand     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (go_calc) begin
              state <= CALC;
`ifdef CORE_ALU_SEQ_MULDIV_EN
              cnt    <= '0;
              acc_hi <= '0;
              acc_lo <= abs_a;
              mcand  <= abs_b;
              op_q   <= i_op;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
`endif
            end else begin
              state     <= DONE;
              result_q  <= fast_res;
              illegal_q <= fast_ill;
            end
          end
        end
`ifdef CORE_ALU_SEQ_MULDIV_EN
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (cnt == SHW'(XLEN-1)) begin
            cnt       <= '0;
            result_q  <= md_res;
            illegal_q <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        DONE: begin
          if (i_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_alu_seq.sv
// tb_core_alu_seq: directed, self-checking bench for core_alu_seq (XLEN=32).
module tb_core_alu_seq;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [4:0]      i_op = '0;
  logic [XLEN-1:0] i_rs1 = '0;
  logic [XLEN-1:0] i_rs2 = '0;
  logic [XLEN-1:0] i_imm = '0;
  logic            i_use_imm = 1'b0;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [XLEN-1:0] o_result;
  logic            o_illegal;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] exp_q[$];

  core_alu_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_op      (i_op),
    .i_rs1     (i_rs1),
    .i_rs2     (i_rs2),
    .i_imm     (i_imm),
    .i_use_imm (i_use_imm),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_illegal (o_illegal),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request and hold it for exactly the accepting edge, then
  // scramble the request inputs so late sampling would show up.
  task automatic send(input logic [4:0] op, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm,
                      input logic use_imm);
    int guard;
    guard = 0;
    while (!o_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before_send", o_ready, 1);
    i_valid   = 1'b1;
    i_op      = op;
    i_rs1     = a;
    i_rs2     = b;
    i_imm     = imm;
    i_use_imm = use_imm;
    @(posedge clk); #1;
    i_valid   = 1'b0;
    i_op      = 5'($urandom_range(0, 31));
    i_rs1     = $urandom;
    i_rs2     = $urandom;
    i_imm     = $urandom;
    i_use_imm = 1'($urandom_range(0, 1));
  endtask

  // Latency 1 means o_valid is already high in the cycle after acceptance.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] imm, input logic use_imm,
                        input logic [XLEN-1:0] exp_res, input logic exp_ill,
                        input int exp_lat);
    int lat;
    logic [XLEN-1:0] exp_v;
    exp_q.push_back(exp_res);
    send(op, a, b, imm, use_imm);
    wait_valid(lat);
    exp_v = exp_q.pop_front();
    if (!o_valid) check({tag, "_timeout"}, o_valid, 1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, o_result, exp_v);
    check({tag, "_ill"}, o_illegal, exp_ill);
    ack();
  endtask

  initial begin
    int lat;
    int seen;

    // Reset state
    #12;
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_result", o_result, 0);
    check("rst_illegal", o_illegal, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ALU ops
    run_op("add",   5'd0, 32'h09439AD4, 32'h00531794, 32'h0, 1'b0, 32'h0996B268, 1'b0, 1);
    run_op("sra",   5'd7, 32'h8E5460F5, 32'h0, 32'h00000024, 1'b1, 32'hF8E5460F, 1'b0, 1);
    run_op("sub",   5'd1, 32'd5, 32'd7, 32'h0, 1'b0, 32'hFFFFFFFE, 1'b0, 1);
    run_op("sll",   5'd2, 32'd1, 32'h0000003F, 32'h0, 1'b0, 32'h80000000, 1'b0, 1);
    run_op("slt",   5'd3, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 32'd1, 1'b0, 1);
    run_op("sltu0", 5'd4, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 32'd0, 1'b0, 1);
    run_op("sltu1", 5'd4, 32'd1, 32'hFFFFFFFF, 32'h0, 1'b0, 32'd1, 1'b0, 1);
    run_op("xor",   5'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 1'b0, 32'h0FF00FF0, 1'b0, 1);
    run_op("srl",   5'd6, 32'h80000000, 32'h0, 32'h00000004, 1'b1, 32'h08000000, 1'b0, 1);
    run_op("or",    5'd8, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 1'b0, 32'hFFF0FFF0, 1'b0, 1);
    run_op("and",   5'd9, 32'hF0F0F0F0, 32'h0, 32'hFF00FF00, 1'b1, 32'hF000F000, 1'b0, 1);
    run_op("ill18", 5'd18, 32'h12345678, 32'h1, 32'h0, 1'b0, 32'h0, 1'b1, 1);
    run_op("ill31", 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, 1'b1, 1);

`ifdef CORE_ALU_SEQ_MULDIV_EN
    // Iterative multiply/divide and division special cases
    run_op("mul",    5'd10, 32'd7, 32'hFFFFFFFD, 32'h0, 1'b0, 32'hFFFFFFEB, 1'b0, 33);
    run_op("mulh",   5'd11, 32'd7, 32'hFFFFFFFD, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0, 33);
    run_op("mulhsu", 5'd12, 32'hFFFFFFFF, 32'd2, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0, 33);
    run_op("mulhu",  5'd13, 32'd7, 32'hFFFFFFFD, 32'h0, 1'b0, 32'h00000006, 1'b0, 33);
    run_op("divu0",  5'd15, 32'd100, 32'd0, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0, 1);
    run_op("rem0",   5'd16, 32'd100, 32'd0, 32'h0, 1'b0, 32'h00000064, 1'b0, 1);
    run_op("divovf", 5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h80000000, 1'b0, 1);
    run_op("removf", 5'd16, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, 1'b0, 1);
    run_op("div",    5'd14, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 32'hFFFFFFFD, 1'b0, 33);
    run_op("rem",    5'd16, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0, 33);
    run_op("divu",   5'd15, 32'd100, 32'd7, 32'h0, 1'b0, 32'd14, 1'b0, 33);
    run_op("remu",   5'd17, 32'd100, 32'd7, 32'h0, 1'b0, 32'd2, 1'b0, 33);
`else
    // Without the mul/div unit these ops are one-cycle illegal
    run_op("mul_ill",  5'd10, 32'd7, 32'hFFFFFFFD, 32'h0, 1'b0, 32'h0, 1'b1, 1);
    run_op("mulh_ill", 5'd11, 32'd7, 32'hFFFFFFFD, 32'h0, 1'b0, 32'h0, 1'b1, 1);
    run_op("divu_ill", 5'd15, 32'd100, 32'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1);
    run_op("remu_ill", 5'd17, 32'd100, 32'd7, 32'h0, 1'b0, 32'h0, 1'b1, 1);
`endif

    // Backpressure: three cycles of i_ready=0 in DONE
    send(5'd0, 32'd3, 32'd4, 32'h0, 1'b0);
    wait_valid(lat);
    check("bp_lat", lat, 1);
    for (int i = 0; i < 3; i++) begin
      check("bp_result", o_result, 7);
      check("bp_valid", o_valid, 1);
      check("bp_ready", o_ready, 0);
      @(posedge clk); #1;
    end
    ack();
    check("bp_idle_ready", o_ready, 1);
    check("bp_idle_valid", o_valid, 0);

    // Reset while an operation is in flight
`ifdef CORE_ALU_SEQ_MULDIV_EN
    send(5'd14, 32'd100, 32'd7, 32'h0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("mid_calc_state", dbg_state, 1);
`else
    send(5'd14, 32'd100, 32'd7, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("mid_done_state", dbg_state, 2);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", o_valid, 0);
    check("rst_mid_ready", o_ready, 1);
    check("rst_mid_result", o_result, 0);
    check("rst_mid_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    check("no_stale_result", seen, 0);
    run_op("add_after_rst", 5'd0, 32'd1, 32'd1, 32'h0, 1'b0, 32'd2, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/core_alu_seq.md
CORE_ALU_SEQ -- requirements
Module: core_alu_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; legal values are 16, 32 and 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_valid, input, 1 bit: a request is present.
REQ-005 The block SHALL have port o_ready, output, 1 bit: the block can accept a request this cycle.
REQ-006 The block SHALL have port i_op, input, 5 bits: encoded operation, ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 MUL=10 MULH=11 MULHSU=12 MULHU=13 DIV=14 DIVU=15 REM=16 REMU=17.
REQ-007 The block SHALL have port i_rs1, input, XLEN bits: operand A.
REQ-008 The block SHALL have ports i_rs2 and i_imm, input, XLEN bits each: the register and immediate candidates for operand B.
REQ-009 The block SHALL have port i_use_imm, input, 1 bit: operand B = i_imm when 1, else i_rs2.
REQ-010 The block SHALL have port o_valid, output, 1 bit: o_result is valid.
REQ-011 The block SHALL have port i_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-012 The block SHALL have port o_result, output, XLEN bits: the operation result.
REQ-013 The block SHALL have port o_illegal, output, 1 bit: qualified by o_valid; the accepted op was unsupported.

Function
REQ-014 A request SHALL be accepted on a cycle with i_valid=1 and o_ready=1; all inputs are sampled on that edge only.
REQ-015 The FSM SHALL have states IDLE, CALC and DONE; o_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-016 Ops 0-9, illegal ops, and the division special cases SHALL go IDLE->DONE: result is valid one cycle after acceptance.
REQ-017 Multiply and divide ops SHALL go IDLE->CALC, iterate one bit per cycle for exactly XLEN cycles, then enter DONE: result is valid XLEN+1 cycles after acceptance.
REQ-018 The block SHALL leave DONE for IDLE on a cycle with i_ready=1; o_result and o_illegal stay stable while i_ready=0.
REQ-019 Shift ops SHALL use only the low log2(XLEN) bits of operand B; SRA replicates the sign bit.
REQ-020 SLT and MUL* signedness SHALL follow RV32I/RV32M semantics; SLT and SLTU return 0 or 1, zero-extended.
REQ-021 ADD, SUB and MUL SHALL wrap modulo 2^XLEN; MULH, MULHSU and MULHU return the upper XLEN bits of the 2*XLEN product.
REQ-022 A divisor of 0 SHALL give quotient all-ones and remainder = dividend.
REQ-023 The signed case of the most-negative value divided by -1 SHALL give quotient = dividend and remainder 0.
REQ-024 Op codes 18-31 SHALL give o_result=0 and o_illegal=1.

Reset
REQ-025 While rst_n=0, the FSM SHALL be IDLE, with o_valid=0, o_ready=1, o_result=0, o_illegal=0, and all iteration counters and accumulators 0.
REQ-026 A reset asserted in CALC or DONE SHALL discard the operation; no result is delivered after release.

Configuration
REQ-027 With macro CORE_ALU_SEQ_MULDIV_EN defined, ops 10-17 SHALL be implemented as specified.
REQ-028 Without CORE_ALU_SEQ_MULDIV_EN, the multiplier and divider SHALL NOT be synthesised; ops 10-17 are treated as illegal (1-cycle, o_result=0, o_illegal=1), and the CALC state is unused.

Verification
REQ-029 ADD, rs1=0x09439AD4, rs2=0x00531794 -> o_valid one cycle later, o_result=0x0996B268, o_illegal=0.
REQ-030 SRA, rs1=0x8E5460F5, use_imm=1, imm=0x24 (low 5 bits = 4) -> o_result=0xF8E5460F.
REQ-031 MUL then MULH, rs1=7, rs2=0xFFFFFFFD -> 0xFFFFFFEB and 0xFFFFFFFF, each with o_valid exactly 33 cycles after acceptance.
REQ-032 DIVU 100/0 -> 0xFFFFFFFF; REM 100/0 -> 0x00000064; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; all 1-cycle.
REQ-033 Backpressure: hold i_ready=0 for 3 cycles in DONE -> o_result stable and o_ready=0 throughout; IDLE the cycle after i_ready=1.
REQ-034 Reset: drop rst_n during cycle 10 of a DIV -> o_valid=0 and o_ready=1 immediately; a following ADD 1+1 returns 2.
